message_strip: RTL and testbench

- Inverse of the SHA-2 message builder. Accepts a stream of padded 512-bit blocks and removes the SHA-2 padding: the single '1' marker bit, the zero fill and the 64-bit big-endian length field.
- Emits the original message blocks, with bits beyond the message length zeroed, followed by one status beat carrying the recovered bit length and an error flag.
- Sits on the input side of the test/loopback path: it consumes what the builder produces.

---
 rtl/message_strip.sv | 257 +++++++++++++++++++++++++
 tb/tb_message_strip.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/message_strip.sv
// message_strip: removes SHA-2 padding from a stream of padded 512-bit blocks,
// forwarding the masked message blocks followed by a length/error status beat.
module message_strip #(
  parameter logic CHECK_EN = 1'b1,
  parameter int   CNT_W    = 56
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [511:0] data_in,
  input  logic         data_in_last,
  input  logic         data_in_valid,
  output logic         data_in_ready,
  output logic [511:0] data_out,
  output logic         data_out_last,
  output logic         data_out_valid,
  input  logic         data_out_ready,
  output logic [63:0]  status_size,
  output logic         status_err,
  output logic         status_valid,
  input  logic         status_ready
);

  typedef enum logic [2:0] {
    EMPTY,
    HOLD,
    DECIDE,
    OUT_BUF,
    OUT_FIN,
    STATUS
  } state_t;

  localparam logic [511:0] PAD_AREA = {{448{1'b1}}, {64{1'b0}}};

  // Top k bits set, the rest clear; k ranges 0..512.
  function automatic logic [511:0] keep_mask(input logic [9:0] k);
    return ~({512{1'b1}} >> k);
  endfunction

  state_t           state_q, state_d;
  logic [511:0]     blk_q, blk_d;
  logic             blk_vld_q, blk_vld_d;
  logic             blk_last_q, blk_last_d;
  logic [511:0]     fin_q, fin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             started_q, started_d;
  logic             beat_loaded_q, beat_loaded_d;
  logic [511:0]     dout_q, dout_d;
  logic             dout_last_q, dout_last_d;
  logic             dout_valid_q, dout_valid_d;
  logic [63:0]      st_size_q, st_size_d;
  logic             st_err_q, st_err_d;
  logic             st_valid_q, st_valid_d;

  logic [63:0]      len;
  logic [8:0]       r;
  logic [8:0]       marker_idx;
  logic [511:0]     r_mask;
  logic [511:0]     r1_mask;
  logic [64:0]      exp_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             case_a, case_b, case_c;
  logic             cnt_bad, fmt_bad, err;
  logic             hold_ready;

  assign len        = fin_q[63:0];
  assign r          = len[8:0];
  assign marker_idx = 9'd511 - r;
  assign r_mask     = keep_mask({1'b0, r});
  assign r1_mask    = keep_mask({1'b0, r} + 10'd1);
  assign exp_cnt    = ((({1'b0, len}) + 65'd64) >> 9) + 65'd1;
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  assign case_b = (r >= 9'd448);
  assign case_c = (r == 9'd0) && (len != 64'd0);
  assign case_a = !case_b && !case_c;

  // A saturated counter can never prove the block count, so it always flags.
  assign cnt_bad = (65'(cnt_q) != exp_cnt) || (&cnt_q);

  always_comb begin
    fmt_bad = 1'b0;
    if (case_a) begin
      fmt_bad = !fin_q[marker_idx] || (|(fin_q & ~r1_mask & PAD_AREA));
    end else if (!blk_vld_q) begin
      fmt_bad = 1'b1;
    end else if (case_b) begin
      fmt_bad = !blk_q[marker_idx] || (|(blk_q & ~r1_mask)) || (|fin_q[511:64]);
    end else begin
      fmt_bad = !fin_q[511] || (|fin_q[510:64]);
    end
  end

  assign err        = CHECK_EN ? (cnt_bad || fmt_bad) : 1'b0;
  assign hold_ready = !dout_valid_q || data_out_ready;

  // Next-state, datapath and handshake control.
  always_comb begin
    state_d       = state_q;
    blk_d         = blk_q;
    blk_vld_d     = blk_vld_q;
    blk_last_d    = blk_last_q;
    fin_d         = fin_q;
    cnt_d         = cnt_q;
    started_d     = 1'b1;
    beat_loaded_d = beat_loaded_q;
    dout_d        = dout_q;
    dout_last_d   = dout_last_q;
    dout_valid_d  = dout_valid_q;
    st_size_d     = st_size_q;
    st_err_d      = st_err_q;
    st_valid_d    = st_valid_q;
    data_in_ready = 1'b0;

    if (dout_valid_q && data_out_ready) begin
      dout_valid_d = 1'b0;
    end

    case (state_q)
      EMPTY: begin
        data_in_ready = started_q;
        if (data_in_valid && started_q) begin
          cnt_d = CNT_W'(1);
          if (data_in_last) begin
            fin_d     = data_in;
            blk_vld_d = 1'b0;
            state_d   = DECIDE;
          end else begin
            blk_d     = data_in;
            blk_vld_d = 1'b1;
            state_d   = HOLD;
          end
        end
      end

      HOLD: begin
        data_in_ready = hold_ready;
        if (data_in_valid && hold_ready) begin
          cnt_d = cnt_inc;
          if (data_in_last) begin
            fin_d   = data_in;
            state_d = DECIDE;
          end else begin
            dout_d       = blk_q;
            dout_last_d  = 1'b0;
            dout_valid_d = 1'b1;
            blk_d        = data_in;
          end
        end
      end

      // The masked beats are written back in place so the output states only replay them.
      DECIDE: begin
        st_size_d     = len;
        st_err_d      = err;
        beat_loaded_d = 1'b0;
        if (case_a || !blk_vld_q) begin
          fin_d      = fin_q & r_mask;
          blk_last_d = 1'b0;
          state_d    = blk_vld_q ? OUT_BUF : OUT_FIN;
        end else begin
          if (case_b) begin
            blk_d = blk_q & r_mask;
          end
          blk_last_d = 1'b1;
          state_d    = OUT_BUF;
        end
      end

      OUT_BUF: begin
        if (!beat_loaded_q) begin
          if (hold_ready) begin
            dout_d        = blk_q;
            dout_last_d   = blk_last_q;
            dout_valid_d  = 1'b1;
            beat_loaded_d = 1'b1;
          end
        end else if (data_out_ready) begin
          beat_loaded_d = 1'b0;
          if (blk_last_q) begin
            st_valid_d = 1'b1;
            state_d    = STATUS;
          end else begin
            state_d = OUT_FIN;
          end
        end
      end

      OUT_FIN: begin
        if (!beat_loaded_q) begin
          if (hold_ready) begin
            dout_d        = fin_q;
            dout_last_d   = 1'b1;
            dout_valid_d  = 1'b1;
            beat_loaded_d = 1'b1;
          end
        end else if (data_out_ready) begin
          beat_loaded_d = 1'b0;
          st_valid_d    = 1'b1;
          state_d       = STATUS;
        end
      end

      STATUS: begin
        if (status_ready) begin
          st_valid_d = 1'b0;
          state_d    = EMPTY;
        end
      end

      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= EMPTY;
      blk_q         <= '0;
      blk_vld_q     <= 1'b0;
      blk_last_q    <= 1'b0;
      fin_q         <= '0;
      cnt_q         <= '0;
      started_q     <= 1'b0;
      beat_loaded_q <= 1'b0;
      dout_q        <= '0;
      dout_last_q   <= 1'b0;
      dout_valid_q  <= 1'b0;
      st_size_q     <= '0;
      st_err_q      <= 1'b0;
      st_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      blk_q         <= blk_d;
      blk_vld_q     <= blk_vld_d;
      blk_last_q    <= blk_last_d;
      fin_q         <= fin_d;
      cnt_q         <= cnt_d;
      started_q     <= started_d;
      beat_loaded_q <= beat_loaded_d;
      dout_q        <= dout_d;
      dout_last_q   <= dout_last_d;
      dout_valid_q  <= dout_valid_d;
      st_size_q     <= st_size_d;
      st_err_q      <= st_err_d;
      st_valid_q    <= st_valid_d;
    end
  end

  assign data_out       = dout_q;
  assign data_out_last  = dout_last_q;
  assign data_out_valid = dout_valid_q;
  assign status_size    = st_size_q;
  assign status_err     = st_err_q;
  assign status_valid   = st_valid_q;

endmodule

// File: tb/tb_message_strip.sv
// Scoreboard bench for message_strip: directed padded messages in, expected
// beats/status queued at issue time and checked by an independent monitor.
module tb_message_strip;

  typedef struct {
    logic [511:0] d;
    logic         l;
  } beat_t;

  typedef struct {
    logic [63:0] s;
    logic        e;
  } stat_t;

  logic         clk = 1'b0;
  logic         nrst;
  logic [511:0] data_in;
  logic         data_in_last;
  logic         data_in_valid;
  logic         data_in_ready;
  logic [511:0] data_out;
  logic         data_out_last;
  logic         data_out_valid;
  logic         data_out_ready;
  logic [63:0]  status_size;
  logic         status_err;
  logic         status_valid;
  logic         status_ready;

  logic         ready_level;
  logic         toggle_en;

  beat_t exp_beats[$];
  stat_t exp_stats[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  message_strip #(.CHECK_EN(1'b1), .CNT_W(56)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .data_in        (data_in),
    .data_in_last   (data_in_last),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_last  (data_out_last),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .status_size    (status_size),
    .status_err     (status_err),
    .status_valid   (status_valid),
    .status_ready   (status_ready)
  );

  // Compare one value and keep the running tallies.
  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one padded block and wait (bounded) for it to be accepted.
  task automatic applyStimulus(input logic [511:0] d, input logic l);
    int waited;
    data_in       = d;
    data_in_last  = l;
    data_in_valid = 1'b1;
    waited        = 0;
    forever begin
      @(negedge clk);
      if (data_in_ready) break;
      waited++;
      if (waited > 300) begin
        total++;
        bad++;
        $display("[TB] FAIL in_accept_timeout: got ready=0 expected ready=1 within 300 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    data_in_last  = 1'b0;
  endtask

  task automatic pushBeat(input logic [511:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    exp_beats.push_back(b);
  endtask

  task automatic pushStatus(input logic [63:0] s, input logic e);
    stat_t t;
    t.s = s;
    t.e = e;
    exp_stats.push_back(t);
  endtask

  // Wait until every queued expectation has been consumed by the monitor.
  task automatic waitDrain();
    int waited;
    waited = 0;
    while (exp_beats.size() != 0 || exp_stats.size() != 0) begin
      @(negedge clk);
      waited++;
      if (waited > 500) begin
        total++;
        bad++;
        $display("[TB] FAIL drain_timeout: got beats=%0d stats=%0d pending expected 0",
                 exp_beats.size(), exp_stats.size());
        exp_beats.delete();
        exp_stats.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Output-ready driver: either a steady level or a per-cycle toggle.
  initial begin
    data_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      data_out_ready = toggle_en ? !data_out_ready : ready_level;
    end
  end

  // Monitor: every transfer seen on the output side pops one expectation.
  initial begin
    beat_t b;
    stat_t t;
    forever begin
      @(negedge clk);
      if (nrst && data_out_valid && data_out_ready) begin
        if (exp_beats.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_beat: got data %h expected no beat", data_out);
        end else begin
          b = exp_beats.pop_front();
          checkOutput("beat_data", data_out, b.d);
          checkOutput("beat_last", 512'(data_out_last), 512'(b.l));
        end
      end
      if (nrst && status_valid && status_ready) begin
        if (exp_stats.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_status: got size %0d expected no status", status_size);
        end else begin
          t = exp_stats.pop_front();
          checkOutput("status_size", 512'(status_size), 512'(t.s));
          checkOutput("status_err", 512'(status_err), 512'(t.e));
        end
      end
    end
  end

  initial begin
    logic [511:0] abc_blk, abc_out;
    logic [511:0] b448_0, b448_1, o448;
    logic [511:0] b512_0, b512_1;
    logic [511:0] b0_blk;
    logic [511:0] m0, m1, m2, m3, o3;
    int waited;

    abc_blk = {32'h61626380, 416'b0, 64'd24};
    abc_out = {24'h616263, 488'b0};
    b448_0  = {{56{8'h41}}, 8'h80, 56'b0};
    b448_1  = {448'b0, 64'd448};
    o448    = {{56{8'h41}}, 64'b0};
    b512_0  = {512{1'b1}};
    b512_1  = {1'b1, 447'b0, 64'd512};
    b0_blk  = {1'b1, 511'b0};
    m0      = {16{32'h01010101}};
    m1      = {16{32'h02020202}};
    m2      = {16{32'h03030303}};
    m3      = {{33{8'h04}}, 8'h80, 176'b0, 64'd1800};
    o3      = {{33{8'h04}}, 248'b0};

    nrst          = 1'b0;
    data_in       = '0;
    data_in_last  = 1'b0;
    data_in_valid = 1'b0;
    status_ready  = 1'b1;
    ready_level   = 1'b1;
    toggle_en     = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", 512'(data_in_ready), 512'(1'b0));
    checkOutput("rst_out_valid", 512'(data_out_valid), 512'(1'b0));
    checkOutput("rst_out_data", data_out, 512'b0);
    checkOutput("rst_status_valid", 512'(status_valid), 512'(1'b0));
    checkOutput("rst_status_size", 512'(status_size), 512'b0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_first_cycle", 512'(data_in_ready), 512'(1'b0));
    @(negedge clk);
    checkOutput("in_ready_after_reset", 512'(data_in_ready), 512'(1'b1));
    @(posedge clk);
    #1;

    $display("[TB] abc single block");
    pushBeat(abc_out, 1'b1);
    pushStatus(64'd24, 1'b0);
    applyStimulus(abc_blk, 1'b1);
    waitDrain();

    $display("[TB] L=448, marker in first block");
    pushBeat(o448, 1'b1);
    pushStatus(64'd448, 1'b0);
    applyStimulus(b448_0, 1'b0);
    applyStimulus(b448_1, 1'b1);
    waitDrain();

    $display("[TB] L=512, exact block boundary");
    pushBeat(b512_0, 1'b1);
    pushStatus(64'd512, 1'b0);
    applyStimulus(b512_0, 1'b0);
    applyStimulus(b512_1, 1'b1);
    waitDrain();

    $display("[TB] L=0 empty message");
    pushBeat(512'b0, 1'b1);
    pushStatus(64'd0, 1'b0);
    applyStimulus(b0_blk, 1'b1);
    waitDrain();

    $display("[TB] length field inconsistent with block count");
    pushBeat(abc_out, 1'b1);
    pushStatus(64'h418, 1'b1);
    applyStimulus({32'h61626380, 416'b0, 64'h418}, 1'b1);
    waitDrain();

    $display("[TB] marker bit missing");
    pushBeat(abc_out, 1'b1);
    pushStatus(64'd24, 1'b1);
    applyStimulus({32'h61626300, 416'b0, 64'd24}, 1'b1);
    waitDrain();

    $display("[TB] 4-block L=1800 with backpressure");
    status_ready = 1'b0;
    toggle_en    = 1'b1;
    pushBeat(m0, 1'b0);
    pushBeat(m1, 1'b0);
    pushBeat(m2, 1'b0);
    pushBeat(o3, 1'b1);
    pushStatus(64'd1800, 1'b0);
    applyStimulus(m0, 1'b0);
    applyStimulus(m1, 1'b0);
    applyStimulus(m2, 1'b0);
    applyStimulus(m3, 1'b1);
    waited = 0;
    while (!status_valid && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("status_valid_seen", 512'(status_valid), 512'(1'b1));
    repeat (5) begin
      @(negedge clk);
      checkOutput("in_ready_blocked", 512'(data_in_ready), 512'(1'b0));
    end
    @(posedge clk);
    #1;
    status_ready = 1'b1;
    toggle_en    = 1'b0;
    ready_level  = 1'b1;
    waitDrain();

    $display("[TB] reset while holding a block");
    ready_level = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(m0, 1'b0);
    applyStimulus(m1, 1'b0);
    @(negedge clk);
    checkOutput("hold_out_pending", 512'(data_out_valid), 512'(1'b1));
    @(posedge clk);
    #1;
    nrst = 1'b0;
    #2;
    checkOutput("midrst_out_valid", 512'(data_out_valid), 512'(1'b0));
    checkOutput("midrst_out_data", data_out, 512'b0);
    checkOutput("midrst_in_ready", 512'(data_in_ready), 512'(1'b0));
    checkOutput("midrst_status_valid", 512'(status_valid), 512'(1'b0));
    @(posedge clk);
    #1;
    nrst        = 1'b1;
    ready_level = 1'b1;
    @(posedge clk);
    #1;
    pushBeat(abc_out, 1'b1);
    pushStatus(64'd24, 1'b0);
    applyStimulus(abc_blk, 1'b1);
    waitDrain();

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "[TB] global timeout");
  end

endmodule
